sw_btn_user_logic: RTL and testbench

- Read-side counterpart of the LED write logic in the same AXI4-Lite slave peripheral.
- Synchronises and debounces 8 slide switches and 5 push buttons.
- Captures button-press events in a sticky clear-on-read register.
- Returns the selected register word to the AXI read-data path, one cycle after a read strobe.

---
 rtl/sw_btn_pkg.sv | 15 +
 rtl/sw_btn_user_logic_debounce_bit.sv | 50 +++++
 rtl/sw_btn_user_logic.sv | 119 +++++++++++
 tb/tb_sw_btn_user_logic.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_btn_pkg.sv
// sw_btn_pkg
//   Shared constants for the switch/button read-side logic of the AXI4-Lite
//   peripheral: register word indices and input counts.
package sw_btn_pkg;

  localparam int NUM_SW  = 8;
  localparam int NUM_BTN = 5;

  // Word indices into the read register map
  localparam logic [1:0] REG_SW   = 2'd0;
  localparam logic [1:0] REG_BTN  = 2'd1;
  localparam logic [1:0] REG_EVT  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

endpackage

// File: rtl/sw_btn_user_logic_debounce_bit.sv
// debounce_bit
//   Two-flop synchroniser, stability counter and debounced level for one raw
//   asynchronous input.
//   Ports:
//     S_AXI_ACLK     in  clock, rising edge
//     S_AXI_ARESETN  in  asynchronous reset, active high
//     din            in  raw asynchronous input
//     dout           out debounced level
//   Parameter DEBOUNCE_CYCLES (2..2^24): number of consecutive cycles the
//   synchronised value must differ from dout before dout follows it.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  // The count only advances while the synced value disagrees with dout, so
  // any return to agreement (a short glitch) restarts it from zero. The
  // counter tops out at CNT_MAX and is cleared there, so it never wraps.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      if (sync_2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        dout <= sync_2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_btn_user_logic.sv
// sw_btn_user_logic
//   Read side of the AXI4-Lite LED/switch/button peripheral. Debounces 8
//   switches and 5 buttons, latches button presses in a clear-on-read event
//   register and returns the addressed word one cycle after a read strobe.
//   Ports:
//     S_AXI_ACLK     in  clock, rising edge
//     S_AXI_ARESETN  in  asynchronous reset, active high
//     slv_reg_rden   in  one-cycle read strobe
//     axi_araddr     in  latched read address (word = [ADDR_LSB+1:ADDR_LSB])
//     SW             in  raw switches
//     BTN            in  raw buttons, 1 = pressed
//     reg_data_out   out read data
//     irq            out |BTN_EVT delayed one cycle (only with SW_BTN_IRQ_EN)
//   Register words: 0 = switches, 1 = buttons, 2 = button events
//   (clear-on-read), 3 = status ({31'b0, irq} with SW_BTN_IRQ_EN, else 0).
//   Build option: define SW_BTN_IRQ_EN to add the irq output.
module sw_btn_user_logic
  import sw_btn_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int ADDR_LSB           = 2,
  parameter int DEBOUNCE_CYCLES    = 1000000
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          slv_reg_rden,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic [NUM_SW-1:0]             SW,
  input  logic [NUM_BTN-1:0]            BTN,
`ifdef SW_BTN_IRQ_EN
  output logic                          irq,
`endif
  output logic [31:0]                   reg_data_out
);

  localparam int NUM_IN = NUM_SW + NUM_BTN;

  logic [NUM_IN-1:0]  raw_in;
  logic [NUM_IN-1:0]  db_in;
  logic [NUM_SW-1:0]  sw_db;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] btn_db_q;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_evt;
  logic [1:0]         rd_idx;
  logic               evt_rd;
  logic [31:0]        stat_word;
  logic [31:0]        rd_word;
  logic               unused_addr;

  // Switches occupy the low bits, buttons the high bits of one vector
  assign raw_in = {BTN, SW};
  assign sw_db  = db_in[NUM_SW-1:0];
  assign btn_db = db_in[NUM_IN-1:NUM_SW];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .S_AXI_ACLK   (S_AXI_ACLK),
      .S_AXI_ARESETN(S_AXI_ARESETN),
      .din          (raw_in[i]),
      .dout         (db_in[i])
    );
  end

  // Only the word index is decoded; the remaining address bits are ignored.
  assign unused_addr = ^axi_araddr;
  assign rd_idx      = axi_araddr[ADDR_LSB+1:ADDR_LSB];
  assign evt_rd      = slv_reg_rden && (rd_idx == REG_EVT);
  assign btn_rise    = btn_db & ~btn_db_q;

  // A clearing read and a new rising edge in the same cycle: the clear is
  // applied first and the new edge is OR-ed in afterwards, so it survives.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN) begin
      btn_db_q <= '0;
      btn_evt  <= '0;
    end else begin
      btn_db_q <= btn_db;
      btn_evt  <= (evt_rd ? '0 : btn_evt) | btn_rise;
    end
  end

`ifdef SW_BTN_IRQ_EN
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN) begin
      irq <= 1'b0;
    end else begin
      irq <= |btn_evt;
    end
  end

  assign stat_word = {31'b0, irq};
`else
  assign stat_word = 32'h0;
`endif

  always_comb begin
    rd_word = 32'h0;
    case (rd_idx)
      REG_SW:   rd_word = {{(32-NUM_SW){1'b0}}, sw_db};
      REG_BTN:  rd_word = {{(32-NUM_BTN){1'b0}}, btn_db};
      REG_EVT:  rd_word = {{(32-NUM_BTN){1'b0}}, btn_evt};
      REG_STAT: rd_word = stat_word;
      default:  rd_word = 32'h0;
    endcase
  end

  // Read data is captured on the strobe and held until the next strobe.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN) begin
      reg_data_out <= 32'h0;
    end else if (slv_reg_rden) begin
      reg_data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_sw_btn_user_logic.sv
// tb_sw_btn_user_logic
//   Directed and randomized stimulus for sw_btn_user_logic with
//   DEBOUNCE_CYCLES=4. A behavioural model tracks the debounced levels,
//   button events, irq and read data; every cycle the DUT outputs are
//   compared with it, and the scenario steps add fixed expected values.
//   Build option: SW_BTN_IRQ_EN adds the irq port and its checks.
module tb_sw_btn_user_logic;

  localparam int D  = 4;
  localparam int NB = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rden = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [7:0]  sw = 8'h0;
  logic [4:0]  btn = 5'h0;
  logic [31:0] rdata;
`ifdef SW_BTN_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sw_btn_user_logic #(
    .C_S_AXI_ADDR_WIDTH(4),
    .ADDR_LSB          (2),
    .DEBOUNCE_CYCLES   (D)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst),
    .slv_reg_rden (rden),
    .axi_araddr   (addr),
    .SW           (sw),
    .BTN          (btn),
`ifdef SW_BTN_IRQ_EN
    .irq          (irq),
`endif
    .reg_data_out (rdata)
  );

  // Reference model: raw inputs reach the debouncer two edges later; a
  // debounced bit flips once its synced input has disagreed with it for D
  // consecutive edges. Bits 0..7 are switches, 8..12 buttons.
  logic [NB-1:0] m_raw1, m_raw2, m_db, m_db_prev;
  int            m_run [NB];
  logic [4:0]    m_evt;
  logic          m_irq;
  logic [31:0]   m_data;

  function automatic logic [31:0] modelWord(input logic [1:0] idx);
    case (idx)
      2'd0:    return {24'b0, m_db[7:0]};
      2'd1:    return {27'b0, m_db[12:8]};
      2'd2:    return {27'b0, m_evt};
`ifdef SW_BTN_IRQ_EN
      default: return {31'b0, m_irq};
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  task automatic modelReset();
    m_raw1 = '0; m_raw2 = '0; m_db = '0; m_db_prev = '0;
    for (int b = 0; b < NB; b++) m_run[b] = 0;
    m_evt = '0; m_irq = 1'b0; m_data = 32'h0;
  endtask

  task automatic modelEdge();
    logic [4:0]  rise;
    logic [4:0]  n_evt;
    logic [31:0] n_data;
    logic        n_irq;
    rise   = m_db[12:8] & ~m_db_prev[12:8];
    n_data = rden ? modelWord(addr[3:2]) : m_data;
    n_evt  = ((rden && addr[3:2] == 2'd2) ? 5'b0 : m_evt) | rise;
    n_irq  = |m_evt;
    m_db_prev = m_db;
    for (int b = 0; b < NB; b++) begin
      if (m_raw2[b] !== m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_db[b]  = m_raw2[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_raw2 = m_raw1;
    m_raw1 = {btn, sw};
    m_data = n_data;
    m_evt  = n_evt;
    m_irq  = n_irq;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("rdata_model", rdata, m_data);
`ifdef SW_BTN_IRQ_EN
    check("irq_model", {31'b0, irq}, {31'b0, m_irq});
`endif
  endtask

  // One clock: drive the read strobe, step the model at the edge, then
  // compare 1 ns after the edge.
  task automatic applyStimulus(input logic rd, input logic [3:0] a);
    rden = rd;
    addr = a;
    @(posedge clk);
    if (rst) modelReset(); else modelEdge();
    #1;
    rden = 1'b0;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0);
  endtask

  initial begin
    bit found;
    modelReset();

    // Reset held: reads return 0
    sw  = 8'hA5;
    btn = 5'h1F;
    applyStimulus(1'b1, 4'h0);
    applyStimulus(1'b1, 4'h8);
    applyStimulus(1'b0, 4'h0);
    check("reset_hold", rdata, 32'h0);
    #2 rst = 1'b0;

    idle(2 + D + 2);
    applyStimulus(1'b1, 4'h0);
    check("sw_initial", rdata, 32'hA5);

    // Switch glitch shorter than D is filtered, a long hold is accepted
    sw = 8'hA4;
    idle(10);
    applyStimulus(1'b1, 4'h1);
    check("sw_low", rdata, 32'hA4);
    sw = 8'hA5;
    idle(2);
    sw = 8'hA4;
    idle(10);
    applyStimulus(1'b1, 4'h2);
    check("sw_glitch", rdata, 32'hA4);
    sw = 8'hA5;
    idle(10);
    applyStimulus(1'b1, 4'h3);
    check("sw_hold", rdata, 32'hA5);

    // Events from the buttons held since reset, then BTN[2]
    btn = 5'h00;
    idle(10);
    applyStimulus(1'b1, 4'h8);
    check("evt_initial", rdata, 32'h1F);
    applyStimulus(1'b1, 4'h8);
    check("evt_cleared", rdata, 32'h0);
    btn = 5'h04;
    idle(10);
    applyStimulus(1'b1, 4'h4);
    check("btn_pressed", rdata, 32'h4);
    btn = 5'h00;
    idle(10);
    applyStimulus(1'b1, 4'h5);
    check("btn_released", rdata, 32'h0);
    applyStimulus(1'b1, 4'hA);
    check("evt_btn2", rdata, 32'h4);
    applyStimulus(1'b1, 4'h9);
    check("evt_btn2_again", rdata, 32'h0);

    // BTN[4] rising edge coincides with a clearing read
    btn = 5'h01;
    idle(10);
    btn = 5'h11;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_db[12] && !m_db_prev[12]) found = 1'b1;
      else applyStimulus(1'b0, 4'h0);
    end
    if (!found) begin
      errors++;
      $display("[TB] FAIL same_cycle_wait observed timeout expected BTN[4] edge");
    end
    applyStimulus(1'b1, 4'h8);
    check("evt_same_cycle_read", rdata, 32'h1);
    applyStimulus(1'b1, 4'h8);
    check("evt_survivor", rdata, 32'h10);

    // Status word
    btn = 5'h00;
    idle(10);
    applyStimulus(1'b1, 4'h8);
    applyStimulus(1'b1, 4'h8);
`ifdef SW_BTN_IRQ_EN
    btn = 5'h01;
    idle(10);
    check("irq_set", {31'b0, irq}, 32'h1);
    applyStimulus(1'b1, 4'hC);
    check("stat_irq", rdata, 32'h1);
    applyStimulus(1'b1, 4'h8);
    check("evt_for_irq", rdata, 32'h1);
    check("irq_still_set", {31'b0, irq}, 32'h1);
    applyStimulus(1'b0, 4'h0);
    check("irq_cleared", {31'b0, irq}, 32'h0);
`else
    btn = 5'h01;
    idle(10);
    applyStimulus(1'b1, 4'hC);
    check("stat_zero", rdata, 32'h0);
`endif

    // Asynchronous reset one cycle after a read
    applyStimulus(1'b1, 4'h0);
    check("pre_reset_read", rdata, 32'hA5);
    rst = 1'b1;
    #1;
    check("async_reset", rdata, 32'h0);
    modelReset();
    idle(3);
    rst = 1'b0;

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 5) == 0) btn = 5'($urandom);
      if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, 4)] ^= 1'b1;
      applyStimulus($urandom_range(0, 2) == 0, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
